mod_counter: RTL and testbench

- Parametrised modulo-N up/down counter; the next generation of the team's fixed mod-8 rotate counter.
- Adds the following over that counter:
  - configurable width and modulus
  - direction control
  - synchronous clear and parallel load
  - wrap or saturate mode
  - terminal-count, wrap, saturate and load-error status
- Drives rotating selectors (display digit scan, mux select, round-robin pointers) and acts as a cascadable prescaler stage.

---
 rtl/mod_counter_pkg.sv | 27 ++
 rtl/mod_counter_next.sv | 87 ++++++++
 rtl/mod_counter.sv | 75 +++++++
 tb/tb_mod_counter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared constants, priority-decode type and parameter legality check for the modulo-N counter.
package mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  localparam int unsigned MAX_WIDTH = 16;

  // Request selected for the coming edge, after clr > load > en priority.
  typedef enum logic [1:0] {
    ActHold,
    ActClr,
    ActLoad,
    ActStep
  } action_e;

  function automatic bit params_legal(int unsigned width, int unsigned modulus,
                                      int unsigned saturate);
    if (width < 1 || width > MAX_WIDTH) return 1'b0;
    if (modulus < 2 || modulus > (32'd1 << width)) return 1'b0;
    return saturate <= MODE_SAT;
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-state for the modulo-N counter: priority decode, step, wrap/saturate, load check.
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned MODULUS  = 8,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             dir_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o,
  output logic             sat_o,
  output logic             load_err_o
);

  localparam logic [WIDTH:0]   ModExt   = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   OneExt   = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] CountTop = WIDTH'(MODULUS - 1);

  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] step_ext;
  logic           at_end;
  action_e        action;

  assign count_ext = {1'b0, count_i};

  always_comb begin
    if (clr_i) begin
      action = ActClr;
    end else if (load_i) begin
      action = ActLoad;
    end else if (en_i) begin
      action = ActStep;
    end else begin
      action = ActHold;
    end
  end

  always_comb begin
    step_ext = (dir_i == DIR_UP) ? (count_ext + OneExt) : (count_ext - OneExt);
    // MODULUS may equal 2**WIDTH, so the top end is an explicit compare against MODULUS
    // rather than a carry-out; the bottom end shows up as a borrow into the extra bit.
    at_end   = (dir_i == DIR_UP) ? (step_ext == ModExt) : step_ext[WIDTH];
  end

  always_comb begin
    count_o    = count_i;
    wrap_o     = 1'b0;
    sat_o      = 1'b0;
    load_err_o = 1'b0;
    unique case (action)
      ActClr: begin
        count_o = '0;
      end
      ActLoad: begin
        if ({1'b0, load_val_i} >= ModExt) begin
          count_o    = CountTop;
          load_err_o = 1'b1;
        end else begin
          count_o = load_val_i;
        end
      end
      ActStep: begin
        if (!at_end) begin
          count_o = step_ext[WIDTH-1:0];
        end else if (SATURATE == MODE_SAT) begin
          sat_o = 1'b1;
        end else begin
          count_o = (dir_i == DIR_UP) ? '0 : CountTop;
          wrap_o  = 1'b1;
        end
      end
      ActHold: begin
        count_o = count_i;
      end
      default: begin
        count_o = count_i;
      end
    endcase
  end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo-N up/down counter with clear, load, wrap/saturate and status pulses.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned MODULUS  = 8,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] CountTop = WIDTH'(MODULUS - 1);

  if (!params_legal(WIDTH, MODULUS, SATURATE)) begin : g_bad_params
    $error("mod_counter: illegal WIDTH/MODULUS/SATURATE combination");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             load_err_q, load_err_d;

  mod_counter_next #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .count_i    (count_q),
    .dir_i      (dir),
    .en_i       (en),
    .clr_i      (clr),
    .load_i     (load),
    .load_val_i (load_val),
    .count_o    (count_d),
    .wrap_o     (wrap_d),
    .sat_o      (sat_d),
    .load_err_o (load_err_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      sat_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      sat_q      <= sat_d;
      load_err_q <= load_err_d;
    end
  end

  // Combinational so a cascaded stage can gate its enable in the same cycle.
  always_comb begin
    tc = (dir == DIR_UP) ? (count_q == CountTop) : (count_q == '0);
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign sat      = sat_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench: three counter configurations against a modulo-arithmetic model, plus a cascade.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst, clr, load, en, dir, casc_en;
  logic [3:0] lv;

  logic [2:0] c8;
  logic [3:0] c10w, c10s, units, tens;
  logic       tc8, w8, s8, l8, tc10w, w10w, s10w, l10w, tc10s, w10s, s10s, l10s;
  logic       u_tc, u_w, u_s, u_l, t_tc, t_w, t_s, t_l, tens_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) dut8 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv[2:0]), .en(en), .dir(dir),
    .count(c8), .tc(tc8), .wrap(w8), .sat(s8), .load_err(l8)
  );

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut10w (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv), .en(en), .dir(dir),
    .count(c10w), .tc(tc10w), .wrap(w10w), .sat(s10w), .load_err(l10w)
  );

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut10s (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv), .en(en), .dir(dir),
    .count(c10s), .tc(tc10s), .wrap(w10s), .sat(s10s), .load_err(l10s)
  );

  assign tens_en = casc_en & u_tc;

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_units (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0), .en(casc_en), .dir(1'b1),
    .count(units), .tc(u_tc), .wrap(u_w), .sat(u_s), .load_err(u_l)
  );

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_tens (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0), .en(tens_en), .dir(1'b1),
    .count(tens), .tc(t_tc), .wrap(t_w), .sat(t_s), .load_err(t_l)
  );

  logic [3:0] obs_cnt[3];
  logic       obs_tc[3], obs_w[3], obs_s[3], obs_l[3];

  assign obs_cnt[0] = {1'b0, c8};
  assign obs_cnt[1] = c10w;
  assign obs_cnt[2] = c10s;
  assign obs_tc[0] = tc8;
  assign obs_tc[1] = tc10w;
  assign obs_tc[2] = tc10s;
  assign obs_w[0] = w8;
  assign obs_w[1] = w10w;
  assign obs_w[2] = w10s;
  assign obs_s[0] = s8;
  assign obs_s[1] = s10w;
  assign obs_s[2] = s10s;
  assign obs_l[0] = l8;
  assign obs_l[1] = l10w;
  assign obs_l[2] = l10s;

  // Reference model: count sequence as plain arithmetic modulo MODULUS.
  int widths[3] = '{3, 4, 4};
  int mods[3]   = '{8, 10, 10};
  bit satm[3]   = '{1'b0, 1'b0, 1'b1};
  int m_cnt[3]  = '{0, 0, 0};
  bit m_w[3], m_s[3], m_l[3];

  function automatic void model_step(int i);
    int lvi;
    int nxt;
    bit crossed;
    lvi = int'(lv) % (1 << widths[i]);
    m_w[i] = 1'b0;
    m_s[i] = 1'b0;
    m_l[i] = 1'b0;
    if (!rst || clr) begin
      m_cnt[i] = 0;
    end else if (load) begin
      if (lvi >= mods[i]) begin
        m_cnt[i] = mods[i] - 1;
        m_l[i] = 1'b1;
      end else begin
        m_cnt[i] = lvi;
      end
    end else if (en) begin
      crossed = dir ? (m_cnt[i] == mods[i] - 1) : (m_cnt[i] == 0);
      nxt = dir ? (m_cnt[i] + 1) % mods[i] : (m_cnt[i] + mods[i] - 1) % mods[i];
      if (crossed && satm[i]) begin
        m_s[i] = 1'b1;
      end else begin
        m_cnt[i] = nxt;
        m_w[i] = crossed;
      end
    end
  endfunction

  task automatic drive(bit r, bit c, bit ld, int v, bit e, bit d);
    rst  = r;
    clr  = c;
    load = ld;
    lv   = v[3:0];
    en   = e;
    dir  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 1, 5, 1, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_cnt[i] !== 4'd0 || obs_w[i] !== 1'b0 || obs_s[i] !== 1'b0 || obs_l[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d] got cnt=%0d w=%b s=%b l=%b want cnt=0 w=0 s=0 l=0",
                 i, obs_cnt[i], obs_w[i], obs_s[i], obs_l[i]);
      end
    end
    checks++;
    if (units !== 4'd0 || tens !== 4'd0) begin
      errors++;
      $display("FAIL reset_cascade got units=%0d tens=%0d want 0 0", units, tens);
    end
  endtask

  task automatic test_up_wrap();
    int exp;
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 1, 1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp = k % 8;
      checks++;
      if (obs_cnt[0] !== 4'(exp)) begin
        errors++;
        $display("FAIL up_wrap_count k=%0d got %0d want %0d", k, obs_cnt[0], exp);
      end
      checks++;
      if (w8 !== (k == 8)) begin
        errors++;
        $display("FAIL up_wrap_pulse k=%0d got %b want %b", k, w8, (k == 8));
      end
      checks++;
      if (tc8 !== (exp == 7)) begin
        errors++;
        $display("FAIL up_wrap_tc k=%0d got %b want %b", k, tc8, (exp == 7));
      end
    end
  endtask

  task automatic test_down_wrap();
    int exp;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp = (10 - k % 10) % 10;
      checks++;
      if (c10w !== 4'(exp) || w10w !== (k % 10 == 1) || tc10w !== (exp == 0)) begin
        errors++;
        $display("FAIL down_wrap k=%0d got cnt=%0d w=%b tc=%b want cnt=%0d w=%b tc=%b",
                 k, c10w, w10w, tc10w, exp, (k % 10 == 1), (exp == 0));
      end
    end
  endtask

  task automatic test_saturate();
    drive(1, 0, 1, 8, 0, 1);
    tick();
    checks++;
    if (c10s !== 4'd8) begin
      errors++;
      $display("FAIL sat_load got %0d want 8", c10s);
    end
    drive(1, 0, 0, 0, 1, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (c10s !== 4'd9 || s10s !== (k > 1) || w10s !== 1'b0) begin
        errors++;
        $display("FAIL sat_hold k=%0d got cnt=%0d s=%b w=%b want cnt=9 s=%b w=0",
                 k, c10s, s10s, w10s, (k > 1));
      end
    end
    drive(1, 0, 1, 12, 0, 1);
    tick();
    checks++;
    if (c10s !== 4'd9 || l10s !== 1'b1 || s10s !== 1'b0) begin
      errors++;
      $display("FAIL load_err got cnt=%0d l=%b s=%b want cnt=9 l=1 s=0", c10s, l10s, s10s);
    end
    drive(1, 0, 0, 0, 0, 1);
    tick();
    checks++;
    if (c10s !== 4'd9 || l10s !== 1'b0) begin
      errors++;
      $display("FAIL load_err_clear got cnt=%0d l=%b want cnt=9 l=0", c10s, l10s);
    end
  endtask

  task automatic test_priority();
    drive(1, 0, 1, 5, 0, 1);
    tick();
    drive(1, 1, 1, 3, 1, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_cnt[i] !== 4'd0 || obs_w[i] !== 1'b0 || obs_s[i] !== 1'b0 || obs_l[i] !== 1'b0) begin
        errors++;
        $display("FAIL prio_clr[%0d] got cnt=%0d w=%b s=%b l=%b want cnt=0 pulses 0",
                 i, obs_cnt[i], obs_w[i], obs_s[i], obs_l[i]);
      end
    end
    drive(1, 0, 1, 3, 1, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_cnt[i] !== 4'd3) begin
        errors++;
        $display("FAIL prio_load[%0d] got %0d want 3", i, obs_cnt[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 1, 6, 0, 1);
    tick();
    drive(0, 0, 1, 3, 1, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_cnt[i] !== 4'd0 || obs_w[i] !== 1'b0 || obs_s[i] !== 1'b0 || obs_l[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid[%0d] got cnt=%0d w=%b s=%b l=%b want cnt=0 pulses 0",
                 i, obs_cnt[i], obs_w[i], obs_s[i], obs_l[i]);
      end
    end
    drive(1, 0, 0, 0, 1, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_cnt[i] !== 4'd1) begin
        errors++;
        $display("FAIL reset_resume[%0d] got %0d want 1", i, obs_cnt[i]);
      end
    end
  endtask

  task automatic test_random();
    bit m_tc;
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 31) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
            int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      tick();
      for (int i = 0; i < 3; i++) begin
        m_tc = dir ? (m_cnt[i] == mods[i] - 1) : (m_cnt[i] == 0);
        checks++;
        if (obs_cnt[i] !== 4'(m_cnt[i]) || obs_w[i] !== m_w[i] || obs_s[i] !== m_s[i] ||
            obs_l[i] !== m_l[i] || obs_tc[i] !== m_tc) begin
          errors++;
          $display("FAIL random[%0d] n=%0d got cnt=%0d w=%b s=%b l=%b tc=%b want cnt=%0d w=%b s=%b l=%b tc=%b",
                   i, n, obs_cnt[i], obs_w[i], obs_s[i], obs_l[i], obs_tc[i],
                   m_cnt[i], m_w[i], m_s[i], m_l[i], m_tc);
        end
      end
    end
  endtask

  task automatic test_cascade();
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 0, 1);
    casc_en = 1'b1;
    for (int n = 1; n <= 105; n++) begin
      tick();
      checks++;
      if (units !== 4'(n % 10) || tens !== 4'((n / 10) % 10)) begin
        errors++;
        $display("FAIL cascade n=%0d got tens=%0d units=%0d want tens=%0d units=%0d",
                 n, tens, units, (n / 10) % 10, n % 10);
      end
    end
    casc_en = 1'b0;
  endtask

  initial begin
    casc_en = 1'b0;
    drive(1, 0, 0, 0, 0, 1);
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_priority();
    test_reset_mid();
    test_random();
    test_cascade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
